// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: opcode encodings,
// FSM state type and default latencies.
package md_pkg;

   localparam logic [2:0] MD_OP_MULT  = 3'd0;
   localparam logic [2:0] MD_OP_MULTU = 3'd1;
   localparam logic [2:0] MD_OP_DIV   = 3'd2;
   localparam logic [2:0] MD_OP_DIVU  = 3'd3;
   localparam logic [2:0] MD_OP_MTHI  = 3'd4;
   localparam logic [2:0] MD_OP_MTLO  = 3'd5;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing a 64-bit {hi,lo} result
// and a divide-by-zero flag for the DIV/DIVU opcodes.
module md_arith
   import md_pkg::*;
(
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        div_by_zero
);

   logic signed [63:0] a_sext;
   logic signed [63:0] b_sext;
   logic               div_overflow;
   logic [31:0]        safe_b_signed;
   logic [31:0]        safe_b_unsigned;
   logic signed [31:0] s_quo;
   logic signed [31:0] s_rem;
   logic [31:0]        u_quo;
   logic [31:0]        u_rem;

   assign a_sext = {{32{a[31]}}, a};
   assign b_sext = {{32{b[31]}}, b};

   // Divisors are steered away from zero and from the INT_MIN / -1 overflow so
   // the dividers never see an undefined case; those cases are patched below.
   assign div_overflow    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   assign safe_b_signed   = ((b == 32'd0) || div_overflow) ? 32'd1 : b;
   assign safe_b_unsigned = (b == 32'd0) ? 32'd1 : b;

   assign s_quo = $signed(a) / $signed(safe_b_signed);
   assign s_rem = $signed(a) % $signed(safe_b_signed);
   assign u_quo = a / safe_b_unsigned;
   assign u_rem = a % safe_b_unsigned;

   always_comb begin
      result      = 64'd0;
      div_by_zero = 1'b0;
      case (md_op)
         MD_OP_MULT:  result = a_sext * b_sext;
         MD_OP_MULTU: result = {32'd0, a} * {32'd0, b};
         MD_OP_DIV: begin
            div_by_zero = (b == 32'd0);
            if (div_overflow)
               result = {32'd0, 32'h8000_0000};
            else
               result = {s_rem, s_quo};
         end
         MD_OP_DIVU: begin
            div_by_zero = (b == 32'd0);
            result      = {u_rem, u_quo};
         end
         default: result = 64'd0;
      endcase
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: multi-cycle MULT/DIV with a busy countdown,
// single-cycle MTHI/MTLO, and the architectural HI/LO registers.
module ex_muldiv_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   md_state_e        state;
   logic [CNT_W-1:0] count;
   logic [2:0]       pend_op;
   logic [31:0]      pend_a;
   logic [31:0]      pend_b;
   logic [63:0]      arith_result;
   logic             arith_div_by_zero;

   // The datapath only ever sees the operands captured at the start edge, so
   // forwarding changes on rs_val/rt_val during the operation cannot leak in.
   md_arith u_arith (
      .md_op       (pend_op),
      .a           (pend_a),
      .b           (pend_b),
      .result      (arith_result),
      .div_by_zero (arith_div_by_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         count   <= '0;
         busy    <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_op <= 3'd0;
         pend_a  <= 32'd0;
         pend_b  <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  case (md_op)
                     MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
                        pend_op <= md_op;
                        pend_a  <= rs_val;
                        pend_b  <= rt_val;
                        count   <= (md_op == MD_OP_MULT || md_op == MD_OP_MULTU)
                                   ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        busy    <= 1'b1;
                        state   <= ST_BUSY;
                     end
                     MD_OP_MTHI: hi <= rs_val;
                     MD_OP_MTLO: lo <= rs_val;
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               // Completing on count==1 gives exactly N busy cycles after the start edge.
               if (count == CNT_W'(1)) begin
                  count <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                  if (!arith_div_by_zero)
                     {hi, lo} <= arith_result;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
